// File: rtl/fp_to_int_serial.sv
// fp_to_int_serial
//   Serial converter from the 13-bit FP format {s, e[3:0], f[7:0]}, where
//   value = (-1)^s * 0.f * 2^e, to an 8-bit two's-complement integer. The
//   significand is aligned by a one-bit-per-cycle right shifter. The result
//   saturates on overflow (ovf). A nonzero operand that truncates to zero
//   raises udf.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      conversion request, sampled only while ready=1
//   fp[12:0]   operand {s, e, f}; f need not be normalized
//   ready      high while idle
//   done_tick  one-cycle pulse, result registers valid from this cycle
//   int_out    signed result, held until the next completion
//   ovf        result saturated
//   udf        nonzero operand truncated to 0
module fp_to_int_serial (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [12:0] fp,
  output logic        ready,
  output logic        done_tick,
  output logic [7:0]  int_out,
  output logic        ovf,
  output logic        udf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic       s_reg;
  logic [3:0] e_reg;
  logic [7:0] m_reg;
  logic       f_zero;  // captured significand was zero; m_reg alone cannot tell

  logic [7:0] res_int;
  logic       res_ovf;
  logic       res_udf;
  logic       eval;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state always uses non-blocking (<=) so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state and Moore outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done_tick  = 1'b0;
    eval       = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = ALIGN;
      end
      ALIGN: begin
        // Shifting stops once the exponent reaches 8, so the final ALIGN
        // cycle always has e_reg >= 8 and is the evaluation cycle.
        if (e_reg >= 4'd8) begin
          eval       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done_tick  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result evaluation on the aligned magnitude
  //   e_reg only exceeds 8 if the captured exponent did, because the shifter
  //   never increments past 8.
  // ---------------------------------------------------------------------------
  always_comb begin
    res_int = 8'h00;
    res_ovf = 1'b0;
    res_udf = 1'b0;
    if (f_zero) begin
      // Zero in any exponent/sign encoding converts to plain 0.
      res_int = 8'h00;
    end else if ((e_reg > 4'd8) ||
                 (!s_reg && (m_reg > 8'd127)) ||
                 ( s_reg && (m_reg > 8'd128))) begin
      res_ovf = 1'b1;
      res_int = s_reg ? 8'h80 : 8'h7F;
    end else if (m_reg == 8'h00) begin
      res_udf = 1'b1;
    end else begin
      // -128 comes out naturally: the two's complement of 8'h80 is 8'h80.
      res_int = s_reg ? (~m_reg + 8'd1) : m_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand capture, alignment shifter, result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_reg   <= 1'b0;
      e_reg   <= 4'd0;
      m_reg   <= 8'h00;
      f_zero  <= 1'b1;
      int_out <= 8'h00;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        s_reg  <= fp[12];
        e_reg  <= fp[11:8];
        m_reg  <= fp[7:0];
        f_zero <= (fp[7:0] == 8'h00);
      end else if (state == ALIGN && !eval) begin
        m_reg <= {1'b0, m_reg[7:1]};  // truncate toward zero
        e_reg <= e_reg + 4'd1;
      end
      if (eval) begin
        int_out <= res_int;
        ovf     <= res_ovf;
        udf     <= res_udf;
      end
    end
  end

endmodule

// File: tb/tb_fp_to_int_serial.sv
// tb_fp_to_int_serial
//   Scoreboard bench for fp_to_int_serial. Stimulus tasks push the expected
//   result and latency when a start is accepted. A monitor pops and compares
//   on every done_tick.
module tb_fp_to_int_serial;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [12:0] fp;
  logic        ready;
  logic        done_tick;
  logic [7:0]  int_out;
  logic        ovf;
  logic        udf;

  fp_to_int_serial dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .fp        (fp),
    .ready     (ready),
    .done_tick (done_tick),
    .int_out   (int_out),
    .ovf       (ovf),
    .udf       (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] int_out;
    logic       ovf;
    logic       udf;
    int         lat;
    int         t0;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // Monitor: every done_tick must match the oldest outstanding expectation.
  exp_t m_e;
  always @(negedge clk) begin
    if (reset_n && done_tick) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected done_tick");
      end else begin
        m_e = exp_q.pop_front();
        check({m_e.tag, " int_out"}, int'(int_out), int'(m_e.int_out));
        check({m_e.tag, " ovf"},     int'(ovf),     int'(m_e.ovf));
        check({m_e.tag, " udf"},     int'(udf),     int'(m_e.udf));
        check({m_e.tag, " latency"}, cyc - m_e.t0,  m_e.lat);
      end
    end
  end

  // Issue one conversion as soon as the DUT is ready and queue its expectation.
  task automatic issue(input logic [12:0] op, input logic [7:0] ei,
                       input logic eo, input logic eu, input int lat,
                       input string tag);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while (!ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) begin
      fail_now({tag, " ready timeout"});
      return;
    end
    start = 1'b1;
    fp    = op;
    @(posedge clk);
    #1;
    e.tag = tag; e.int_out = ei; e.ovf = eo; e.udf = eu; e.lat = lat; e.t0 = cyc;
    exp_q.push_back(e);
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      fail_now({tag, " done_tick timeout"});
      exp_q.delete();
    end
  endtask

  // Reference integer-to-FP encoder: normalized significand, e = bit length.
  function automatic logic [12:0] int_to_fp(input logic signed [7:0] v);
    logic [7:0] mag;
    int         p;
    mag = v[7] ? (~v + 8'd1) : v;  // -128 -> 8'h80 as unsigned 128
    if (mag == 8'h00) return 13'h0000;
    p = 0;
    for (int i = 0; i < 8; i++) if (mag[i]) p = i;
    return {v[7], 4'(p + 1), 8'(mag << (7 - p))};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] op;
    int          e;
    reset_n = 1'b0;
    start   = 1'b0;
    fp      = 13'h0000;
    repeat (3) @(negedge clk);
    check("reset ready",     int'(ready),     1);
    check("reset done_tick", int'(done_tick), 0);
    check("reset int_out",   int'(int_out),   0);
    check("reset ovf",       int'(ovf),       0);
    check("reset udf",       int'(udf),       0);
    reset_n = 1'b1;

    // Directed vectors: op, int_out, ovf, udf, latency
    issue(13'h07FE, 8'h7F, 1'b0, 1'b0, 2, "e7 FE");
    issue(13'h1880, 8'h80, 1'b0, 1'b0, 1, "neg 128");
    issue(13'h1881, 8'h80, 1'b1, 1'b0, 1, "neg 129 sat");
    issue(13'h0C80, 8'h7F, 1'b1, 1'b0, 1, "e12 sat");
    issue(13'h0080, 8'h00, 1'b0, 1'b1, 9, "e0 udf");
    issue(13'h1000, 8'h00, 1'b0, 1'b0, 9, "neg zero");
    issue(13'h03A0, 8'h05, 1'b0, 1'b0, 6, "e3 A0");
    issue(13'h1F00, 8'h00, 1'b0, 1'b0, 1, "zero e15");
    issue(13'h0880, 8'h7F, 1'b1, 1'b0, 1, "pos 128 sat");
    issue(13'h1701, 8'h00, 1'b0, 1'b1, 2, "neg udf");
    issue(13'h1703, 8'hFF, 1'b0, 1'b0, 2, "neg one");
    drain("directed");

    // Start during ALIGN must be ignored.
    issue(13'h0180, 8'h01, 1'b0, 1'b0, 8, "busy start");
    @(negedge clk);
    start = 1'b1;
    fp    = 13'h07FE;
    @(negedge clk);
    start = 1'b0;
    drain("busy start");
    repeat (12) @(negedge clk);
    check("busy ready", int'(ready), 1);

    // Asynchronous reset during ALIGN aborts the conversion.
    issue(13'h00FF, 8'h00, 1'b0, 1'b1, 9, "abort");
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort ready",   int'(ready),   1);
    check("abort int_out", int'(int_out), 0);
    check("abort ovf",     int'(ovf),     0);
    check("abort udf",     int'(udf),     0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    check("abort no done", exp_q.size(), 0);

    // Round trip over all signed integers, back-to-back on ready.
    for (int i = -128; i < 128; i++) begin
      op = int_to_fp(8'(i));
      e  = int'(op[11:8]);
      issue(op, 8'(i), 1'b0, 1'b0, (e >= 8) ? 1 : 9 - e, $sformatf("rt %0d", i));
    end
    drain("round trip");
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
